// File: rtl/cdm16_mon_pkg.sv
// Shared constants, window FSM state type and the saturating accumulator helper
// for the CDM16 error monitor.
package cdm16_mon_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int SAT_W  = 64;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } mon_state_e;

  // One extra bit of headroom so the compare against lim can never be fooled by a wrap.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0]  sum,
                                               input logic [PROD_W-1:0] ed,
                                               input logic [SAT_W-1:0]  lim);
    logic [SAT_W:0] t;
    t = {1'b0, sum} + {{(SAT_W - PROD_W + 1){1'b0}}, ed};
    return (t > {1'b0, lim}) ? lim : t[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/cdm16_ed_stage.sv
// Two-stage error-distance pipe: stage 1 registers the triple and the exact
// product, stage 2 presents |exact - R| combinationally from those registers.
module cdm16_ed_stage
  import cdm16_mon_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [PROD_W-1:0] in_r,
  output logic              ed_valid,
  output logic [PROD_W-1:0] ed,
  output logic [OP_W-1:0]   op_a,
  output logic [OP_W-1:0]   op_b
);

  logic              v1;
  logic [PROD_W-1:0] r1;
  logic [PROD_W-1:0] exact1;

  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else     v1 <= in_valid & ~flush;
  end

  // Data registers need no reset: they are only observed while v1 is set.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      op_a   <= in_a;
      op_b   <= in_b;
      r1     <= in_r;
      exact1 <= PROD_W'(in_a) * PROD_W'(in_b);
    end
  end

  assign ed_valid = v1;
  assign ed       = (exact1 >= r1) ? (exact1 - r1) : (r1 - exact1);

endmodule

// File: rtl/cdm16_err_monitor.sv
// Error-statistics monitor for the 16x16 carry-disregard multiplier.
// Optional max-ED tracker enabled by defining CDM16_MAXED_EN.
//
// state | meaning
// RUN   | accepting triples until WINDOW_N have been taken
// DRAIN | window full, waiting for the last in-flight sample to update stats
// HOLD  | stats frozen, done high; only clear or rst leaves
module cdm16_err_monitor
  import cdm16_mon_pkg::*;
#(
  parameter int WINDOW_N = 1000000,
  parameter int CNT_W    = 24,
  parameter int SUM_W    = 56
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [PROD_W-1:0] in_r,
  output logic [CNT_W-1:0]  stat_samples,
  output logic [CNT_W-1:0]  stat_errs,
  output logic [SUM_W-1:0]  stat_sum_ed,
  output logic [PROD_W-1:0] stat_max_ed,
  output logic [OP_W-1:0]   stat_max_a,
  output logic [OP_W-1:0]   stat_max_b,
  output logic              done
);

  localparam logic [CNT_W-1:0] WIN_M1  = CNT_W'(WINDOW_N - 1);
  localparam logic [SAT_W-1:0] SUM_MAX = SAT_W'((65'd1 << SUM_W) - 65'd1);

  mon_state_e        state, state_nxt;
  logic [CNT_W-1:0]  acc_cnt;
  logic              accept;
  logic              ed_valid;
  logic [PROD_W-1:0] ed;
  logic [OP_W-1:0]   op_a, op_b;

  assign accept = in_valid & in_ready;

  cdm16_ed_stage u_ed_stage (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear),
    .in_valid (accept),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_r     (in_r),
    .ed_valid (ed_valid),
    .ed       (ed),
    .op_a     (op_a),
    .op_b     (op_b)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (accept && acc_cnt == WIN_M1)        state_nxt = DRAIN;
        DRAIN:   if (ed_valid && stat_samples == WIN_M1) state_nxt = HOLD;
        HOLD:    state_nxt = HOLD;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    in_ready = (state == RUN) & ~clear;
    done     = (state == HOLD);
  end

  // Updates from a sample in flight during clear are dropped: clear wins.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_cnt      <= '0;
      stat_samples <= '0;
      stat_errs    <= '0;
      stat_sum_ed  <= '0;
    end else begin
      if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
      if (ed_valid) begin
        stat_samples <= stat_samples + CNT_W'(1);
        stat_errs    <= stat_errs + CNT_W'(ed != '0);
        stat_sum_ed  <= SUM_W'(sat_add(SAT_W'(stat_sum_ed), ed, SUM_MAX));
      end
    end
  end

`ifdef CDM16_MAXED_EN
  // Strict compare keeps the first sample that reached the maximum.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      stat_max_ed <= '0;
      stat_max_a  <= '0;
      stat_max_b  <= '0;
    end else if (ed_valid && ed > stat_max_ed) begin
      stat_max_ed <= ed;
      stat_max_a  <= op_a;
      stat_max_b  <= op_b;
    end
  end
`else
  assign stat_max_ed = '0;
  assign stat_max_a  = '0;
  assign stat_max_b  = '0;

  logic unused_max;
  assign unused_max = ^{op_a, op_b};
`endif

endmodule

// File: tb/tb_cdm16_err_monitor.sv
// Scoreboard bench for cdm16_err_monitor: the driver predicts stats snapshots from
// the ED/ER rules and queues them with a due cycle; a monitor compares every cycle.
module tb_cdm16_err_monitor;

  localparam int N     = 4;
  localparam int CNT_W = 24;
  localparam int SUM_W = 32;
  localparam logic [63:0] SUM_LIM = (64'd1 << SUM_W) - 64'd1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_a = '0;
  logic [15:0]       in_b = '0;
  logic [31:0]       in_r = '0;
  logic [CNT_W-1:0]  stat_samples;
  logic [CNT_W-1:0]  stat_errs;
  logic [SUM_W-1:0]  stat_sum_ed;
  logic [31:0]       stat_max_ed;
  logic [15:0]       stat_max_a;
  logic [15:0]       stat_max_b;
  logic              done;

  always #5 clk = ~clk;

  cdm16_err_monitor #(.WINDOW_N(N), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_r         (in_r),
    .stat_samples (stat_samples),
    .stat_errs    (stat_errs),
    .stat_sum_ed  (stat_sum_ed),
    .stat_max_ed  (stat_max_ed),
    .stat_max_a   (stat_max_a),
    .stat_max_b   (stat_max_b),
    .done         (done)
  );

  typedef struct {
    int          due;
    logic [63:0] samples;
    logic [63:0] errs;
    logic [63:0] sum;
    logic [63:0] max_ed;
    logic [63:0] max_a;
    logic [63:0] max_b;
    logic [63:0] done;
  } exp_t;

  exp_t q[$];
  exp_t m;
  exp_t cur;
  int   m_acc = 0;
  int   edge_n = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  initial cur = '{default: 0};

  // Monitor: stats must equal the latest snapshot whose due cycle has arrived.
  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].due <= edge_n) cur = q.pop_front();
      chk("samples", 64'(stat_samples), cur.samples);
      chk("errs",    64'(stat_errs),    cur.errs);
      chk("sum_ed",  64'(stat_sum_ed),  cur.sum);
      chk("max_ed",  64'(stat_max_ed),  cur.max_ed);
      chk("max_a",   64'(stat_max_a),   cur.max_a);
      chk("max_b",   64'(stat_max_b),   cur.max_b);
      chk("done",    64'(done),         cur.done);
    end
  end

  task automatic step(input bit v, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] r, input bit clr, input bit rs);
    exp_t        e;
    bit          rdy;
    logic [63:0] ex;
    logic [63:0] ed;
    @(negedge clk);
    rst = rs; clear = clr; in_valid = v; in_a = a; in_b = b; in_r = r;
    #1;
    if (rs || clr) begin
      if (!rs) chk("in_ready_in_clear", 64'(in_ready), 64'd0);
      m_acc = 0;
      m = '{default: 0};
      q.delete();
      e = m;
      e.due = edge_n + 1;
      q.push_back(e);
      mon_en = 1'b1;
    end else begin
      rdy = (m_acc < N);
      chk("in_ready", 64'(in_ready), 64'(rdy));
      if (v && rdy) begin
        ex = 64'(a) * 64'(b);
        ed = (ex >= 64'(r)) ? ex - 64'(r) : 64'(r) - ex;
        m_acc++;
        m.samples = m.samples + 1;
        if (ed != 0) m.errs = m.errs + 1;
        m.sum = (m.sum + ed > SUM_LIM) ? SUM_LIM : m.sum + ed;
`ifdef CDM16_MAXED_EN
        if (ed > m.max_ed) begin
          m.max_ed = ed;
          m.max_a  = 64'(a);
          m.max_b  = 64'(b);
        end
`endif
        m.done = (m_acc == N) ? 64'd1 : 64'd0;
        e = m;
        e.due = edge_n + 2;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), $urandom, 1'b1, 1'b0);
  endtask

  task automatic rand_triple(output logic [15:0] a, output logic [15:0] b, output logic [31:0] r);
    logic [31:0] ex;
    a  = 16'($urandom);
    b  = 16'($urandom);
    ex = 32'(a) * 32'(b);
    case ($urandom_range(0, 2))
      0:       r = ex;
      1:       r = ex ^ 32'($urandom_range(0, 255));
      default: r = $urandom;
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra, rb;
    logic [31:0] rr;

    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    idle(2);

    // exact products, then in_valid held high while done
    step(1'b1, 16'd3,     16'd5,     32'd15,         1'b0, 1'b0);
    step(1'b1, 16'd0,     16'd65535, 32'd0,          1'b0, 1'b0);
    step(1'b1, 16'd65535, 16'd65535, 32'd4294836225, 1'b0, 1'b0);
    step(1'b1, 16'd100,   16'd200,   32'd20000,      1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rand_triple(ra, rb, rr);
      step(1'b1, ra, rb, rr, 1'b0, 1'b0);
    end

    // errors with bubbles: errs=2, sum=14, max 10 at (10,10)
    do_clear();
    idle(1);
    step(1'b1, 16'd10, 16'd10, 32'd90, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 16'd2,  16'd3,  32'd10, 1'b0, 1'b0);
    step(1'b1, 16'd7,  16'd7,  32'd49, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 16'd1,  16'd1,  32'd1,  1'b0, 1'b0);
    idle(3);

    // accumulator saturation
    do_clear();
    for (int i = 0; i < N; i++) step(1'b1, 16'd0, 16'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(3);

    // clear right after an accept discards that sample
    do_clear();
    step(1'b1, 16'd9, 16'd9, 32'd80, 1'b0, 1'b0);
    do_clear();
    idle(3);

    // random windows with gaps, occasional mid-window clear
    for (int w = 0; w < 8; w++) begin
      do_clear();
      for (int k = 0; k < 30; k++) begin
        rand_triple(ra, rb, rr);
        if ($urandom_range(0, 24) == 0)
          do_clear();
        else
          step(1'($urandom_range(0, 1)), ra, rb, rr, 1'b0, 1'b0);
      end
    end

    // reset while the last sample is still in flight
    do_clear();
    for (int i = 0; i < N; i++) begin
      rand_triple(ra, rb, rr);
      step(1'b1, ra, rb, rr, 1'b0, 1'b0);
    end
    step(1'b1, 16'd1, 16'd2, 32'd5, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 16'd4, 16'd4, 32'd17, 1'b0, 1'b0);
    idle(4);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
